// File: rtl/instruction_encoder_pkg.sv
// Shared constants and types for the instruction encoder.
// Opcodes, immediate-format select and immediate range limits.
package instruction_encoder_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int IMM_MIN     = -2048;
    localparam int IMM_MAX     = 2047;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic {
        IMM_I = 1'b0,
        IMM_S = 1'b1
    } imm_sel_e;

endpackage

// File: rtl/instruction_encoder_imm_packer.sv
// Combinational field packing plus signed 12-bit immediate range check.
// Ports: imm_sel/opcode/funct3/rd/rs1/rs2/imm_value in; word, imm_legal out.
module imm_packer
    import instruction_encoder_pkg::*;
(
    input  logic                   imm_sel,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [31:0]            imm_value,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   imm_legal
);

    logic [11:0] imm12;

    assign imm12 = imm_value[11:0];

    // Fits in 12 bits signed iff bits 31..11 are all copies of the sign.
    assign imm_legal = (&imm_value[31:11]) | ~(|imm_value[31:11]);

    always_comb begin
        word = '0;
        if (imm_sel == IMM_S) begin
            word = {imm12[11:5], rs2, rs1, funct3, imm12[4:0], opcode};
        end else begin
            word = {imm12, rs1, funct3, rd, opcode};
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder: single output register with valid/ready handshake,
// emit-address counter, sticky range error and saturating drop counter.
// Ports: clk, reset (sync, active-high); In_Valid/In_Ready request side;
// Imm_Sel, Opcode, Funct3, Rd, Rs1, Rs2, Imm_Value fields; Load_Base,
// Base_Addr; Out_Valid/Out_Ready, Instruction_Code, Instr_Addr;
// Range_Error, Drop_Count status.
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic                   Imm_Sel,
    input  logic [6:0]             Opcode,
    input  logic [2:0]             Funct3,
    input  logic [4:0]             Rd,
    input  logic [4:0]             Rs1,
    input  logic [4:0]             Rs2,
    input  logic [31:0]            Imm_Value,
    input  logic                   Load_Base,
    input  logic [31:0]            Base_Addr,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [INSTR_WIDTH-1:0] Instruction_Code,
    output logic [31:0]            Instr_Addr,
    output logic                   Range_Error,
    output logic [7:0]             Drop_Count
);

    logic [INSTR_WIDTH-1:0] packed_word;
    logic                   imm_legal;
    logic [31:0]            next_addr;
    logic [31:0]            emit_addr;
    logic                   accept;
    logic                   out_fire;
    logic                   unused_base_lsbs;

    imm_packer u_imm_packer (
        .imm_sel   (Imm_Sel),
        .opcode    (Opcode),
        .funct3    (Funct3),
        .rd        (Rd),
        .rs1       (Rs1),
        .rs2       (Rs2),
        .imm_value (Imm_Value),
        .word      (packed_word),
        .imm_legal (imm_legal)
    );

    assign unused_base_lsbs = ^Base_Addr[1:0];

    assign In_Ready = !Out_Valid || Out_Ready;
    assign accept   = In_Valid && In_Ready;
    assign out_fire = Out_Valid && Out_Ready;

    // A base load in the same cycle as a legal word is used by that word.
    assign emit_addr = Load_Base ? {Base_Addr[31:2], 2'b00} : next_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            Out_Valid        <= 1'b0;
            Instruction_Code <= '0;
            Instr_Addr       <= '0;
            next_addr        <= '0;
            Range_Error      <= 1'b0;
            Drop_Count       <= '0;
        end else begin
            if (accept && imm_legal) begin
                // Replaces any word leaving this cycle: no bubble.
                Out_Valid        <= 1'b1;
                Instruction_Code <= packed_word;
                Instr_Addr       <= emit_addr;
                next_addr        <= emit_addr + 32'd4;
            end else begin
                if (out_fire) begin
                    Out_Valid <= 1'b0;
                end
                if (Load_Base) begin
                    next_addr <= emit_addr;
                end
            end
            if (accept && !imm_legal) begin
                Range_Error <= 1'b1;
                if (Drop_Count != 8'hFF) begin
                    Drop_Count <= Drop_Count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder.
// Scoreboard of expected {word, address} checked at each output transfer.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        In_Valid;
    logic        In_Ready;
    logic        Imm_Sel;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [4:0]  Rd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [31:0] Imm_Value;
    logic        Load_Base;
    logic [31:0] Base_Addr;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Instruction_Code;
    logic [31:0] Instr_Addr;
    logic        Range_Error;
    logic [7:0]  Drop_Count;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_addr = 0;
    int          model_drop = 0;

    instruction_encoder dut (
        .clk              (clk),
        .reset            (reset),
        .In_Valid         (In_Valid),
        .In_Ready         (In_Ready),
        .Imm_Sel          (Imm_Sel),
        .Opcode           (Opcode),
        .Funct3           (Funct3),
        .Rd               (Rd),
        .Rs1              (Rs1),
        .Rs2              (Rs2),
        .Imm_Value        (Imm_Value),
        .Load_Base        (Load_Base),
        .Base_Addr        (Base_Addr),
        .Out_Valid        (Out_Valid),
        .Out_Ready        (Out_Ready),
        .Instruction_Code (Instruction_Code),
        .Instr_Addr       (Instr_Addr),
        .Range_Error      (Range_Error),
        .Drop_Count       (Drop_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(
        input bit sel, input logic [6:0] op, input logic [2:0] f3,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input int imm);
        logic [31:0] iv;
        iv = imm;
        if (sel) return {iv[11:5], rs2, rs1, f3, iv[4:0], op};
        return {iv[11:0], rs1, f3, rd, op};
    endfunction

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed %h expected none",
                       Instruction_Code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_code", Instruction_Code, e.code);
                chk("sb_addr", Instr_Addr, e.addr);
            end
        end
    end

    task automatic send(input bit sel, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input int imm, input bit ld, input logic [31:0] base);
        int n;
        bit rdy;
        exp_t e;
        In_Valid  = 1'b1;
        Imm_Sel   = sel;
        Opcode    = op;
        Funct3    = f3;
        Rd        = rd;
        Rs1       = rs1;
        Rs2       = rs2;
        Imm_Value = imm;
        Load_Base = ld;
        Base_Addr = base;
        n = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = (In_Ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        Load_Base = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed no accept expected accept");
        end else begin
            if (ld) model_addr = {base[31:2], 2'b00};
            if (imm >= IMM_MIN && imm <= IMM_MAX) begin
                e.code = model_word(sel, op, f3, rd, rs1, rs2, imm);
                e.addr = model_addr;
                sb.push_back(e);
                model_addr = model_addr + 32'd4;
            end else if (model_drop < 255) begin
                model_drop++;
            end
        end
    endtask

    task automatic idle(input int n);
        In_Valid  = 1'b0;
        Load_Base = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        In_Valid  = 1'b0;
        Load_Base = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        model_addr = 0;
        model_drop = 0;
    endtask

    logic [31:0] back;
    logic [31:0] held_code;

    initial begin
        reset     = 1'b1;
        In_Valid  = 1'b1;
        Imm_Sel   = 1'b0;
        Opcode    = OPC_OP_IMM;
        Funct3    = 3'd0;
        Rd        = 5'd1;
        Rs1       = 5'd1;
        Rs2       = 5'd0;
        Imm_Value = 32'd1;
        Load_Base = 1'b0;
        Base_Addr = 32'd0;
        Out_Ready = 1'b1;

        // Request presented during reset must be discarded.
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        In_Valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_code", Instruction_Code, 32'd0);
        chk("rst_addr", Instr_Addr, 32'd0);
        chk("rst_range", 32'(Range_Error), 32'd0);
        chk("rst_drop", 32'(Drop_Count), 32'd0);
        @(posedge clk);
        #1;

        // I-type, imm -5.
        send(1'b0, OPC_OP_IMM, 3'd0, 5'd5, 5'd6, 5'd9, -5, 1'b0, 32'd0);
        chk("i_code", Instruction_Code, 32'hFFB30293);
        chk("i_addr", Instr_Addr, 32'd0);
        idle(1);

        // S-type, imm 8.
        send(1'b1, OPC_STORE, 3'b010, 5'd31, 5'd2, 5'd7, 8, 1'b0, 32'd0);
        chk("s_code", Instruction_Code, 32'h00712423);
        back = {{20{Instruction_Code[31]}}, Instruction_Code[31:25],
                Instruction_Code[11:7]};
        chk("s_imm_back", back, 32'd8);
        idle(1);

        // Immediate boundaries, back to back.
        send(1'b0, OPC_LOAD, 3'b010, 5'd3, 5'd4, 5'd0, 2047, 1'b0, 32'd0);
        send(1'b1, OPC_STORE, 3'b000, 5'd0, 5'd8, 5'd9, -2048, 1'b0, 32'd0);
        send(1'b0, OPC_OP_IMM, 3'd0, 5'd1, 5'd2, 5'd0, 2048, 1'b0, 32'd0);
        chk("ovf_out_valid", 32'(Out_Valid), 32'd0);
        chk("ovf_range", 32'(Range_Error), 32'd1);
        chk("ovf_drop", 32'(Drop_Count), 32'd1);
        send(1'b1, OPC_STORE, 3'd0, 5'd0, 5'd2, 5'd3, -2049, 1'b0, 32'd0);
        chk("ovf2_drop", 32'(Drop_Count), 32'd2);
        idle(2);

        // Backpressure from address 0.
        do_reset();
        Out_Ready = 1'b0;
        send(1'b0, OPC_OP_IMM, 3'd1, 5'd10, 5'd11, 5'd0, 100, 1'b0, 32'd0);
        held_code = model_word(1'b0, OPC_OP_IMM, 3'd1, 5'd10, 5'd11, 5'd0, 100);
        fork
            send(1'b0, OPC_OP_IMM, 3'd2, 5'd12, 5'd13, 5'd0, -1, 1'b0, 32'd0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(In_Ready), 32'd0);
                    chk("bp_code", Instruction_Code, held_code);
                    chk("bp_addr", Instr_Addr, 32'd0);
                end
                @(posedge clk);
                #1;
                Out_Ready = 1'b1;
            end
        join
        send(1'b1, OPC_STORE, 3'd3, 5'd0, 5'd14, 5'd15, 33, 1'b0, 32'd0);
        idle(2);

        // Base load with simultaneous request, then wrap.
        send(1'b0, OPC_LOAD, 3'd2, 5'd1, 5'd2, 5'd0, 4, 1'b1, 32'hFFFFFFF9);
        chk("lb_addr0", Instr_Addr, 32'hFFFFFFF8);
        send(1'b0, OPC_LOAD, 3'd2, 5'd3, 5'd2, 5'd0, 8, 1'b0, 32'd0);
        send(1'b0, OPC_LOAD, 3'd2, 5'd4, 5'd2, 5'd0, 12, 1'b0, 32'd0);
        chk("lb_wrap", Instr_Addr, 32'd0);
        idle(2);

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) begin
            send(1'b0, OPC_OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0, 4096, 1'b0, 32'd0);
        end
        idle(1);
        chk("sat_drop", 32'(Drop_Count), 32'(model_drop));
        chk("sat_range", 32'(Range_Error), 32'd1);
        chk("sat_out_valid", 32'(Out_Valid), 32'd0);

        // Reset while a word is stalled: it must never transfer.
        Out_Ready = 1'b0;
        send(1'b1, OPC_STORE, 3'd2, 5'd0, 5'd5, 5'd6, 20, 1'b0, 32'd0);
        chk("pend_valid", 32'(Out_Valid), 32'd1);
        void'(sb.pop_back());
        reset    = 1'b1;
        In_Valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
        chk("mid_rst_code", Instruction_Code, 32'd0);
        chk("mid_rst_addr", Instr_Addr, 32'd0);
        chk("mid_rst_range", 32'(Range_Error), 32'd0);
        chk("mid_rst_drop", 32'(Drop_Count), 32'd0);
        reset     = 1'b0;
        Out_Ready = 1'b1;
        idle(5);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 In_Valid  input  1  encode request present.
REQ-004 In_Ready  output  1  request accepted when In_Valid && In_Ready at a clk edge.
REQ-005 Imm_Sel  input  1  0 = I-type (load/ALU-immediate), 1 = S-type (store).
REQ-006 Opcode  input  7;  Funct3  input  3;  Rd  input  5;  Rs1  input  5;  Rs2  input  5  instruction fields.
REQ-007 Imm_Value  input  32  signed immediate to pack.
REQ-008 Load_Base  input  1;  Base_Addr  input  32  loads the emit address (word-aligned, bits[1:0] ignored).
REQ-009 Out_Valid  output  1;  Out_Ready  input  1  output handshake; transfer when both are high.
REQ-010 Instruction_Code  output  32  packed instruction word.
REQ-011 Instr_Addr  output  32  address associated with the current Instruction_Code.
REQ-012 Range_Error  output  1  sticky flag; some request had an immediate outside the signed 12-bit range.
REQ-013 Drop_Count  output  8  number of requests rejected for range, saturating at 255.

Function
REQ-014 Packing, I-type: Instruction_Code = {Imm[11:0], Rs1, Funct3, Rd, Opcode}; Rs2 is ignored.
REQ-015 Packing, S-type: Instruction_Code = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}; Rd is ignored.
REQ-016 Range check: the immediate is legal iff Imm_Value[31:11] are all equal (range -2048..2047).
REQ-017 Output register: there is a single output register; In_Ready = !Out_Valid || Out_Ready (combinational).
REQ-018 Legal accepted request: the output register loads and Out_Valid is high on the next cycle (latency 1).
REQ-019 Illegal accepted request:
  - request is consumed and nothing is emitted;
  - Range_Error sets;
  - Drop_Count increments;
  - Out_Valid clears if the held word is transferred in the same cycle.
REQ-020 While Out_Valid && !Out_Ready, Instruction_Code and Instr_Addr hold stable and In_Ready = 0.
REQ-021 Same-cycle output transfer and input accept: the new word replaces the old with no bubble (full throughput).
REQ-022 Address counter: an internal Next_Addr is latched into Instr_Addr with each legal word; Next_Addr += 4 on each legal accept.
REQ-023 Address wrap: 0xFFFFFFFC wraps to 0x00000000.
REQ-024 Load_Base sets Next_Addr = {Base_Addr[31:2], 2'b00}.
  - A legal accept in the same cycle uses the new base and then advances to base+4.
  - Load_Base has priority over the increment.
REQ-025 Drop_Count saturates at 255; Range_Error is cleared only by reset.

Reset
REQ-026 When reset is high at a clk edge:
  - Out_Valid = 0, Instruction_Code = 0, Instr_Addr = 0, Next_Addr = 0, Range_Error = 0, Drop_Count = 0.
REQ-027 Reset has priority over every other event; an output word pending mid-handshake is discarded.
REQ-028 During reset In_Ready is 1, but any request presented in that cycle is discarded.

Structure
REQ-029 A shared package holds:
  - the opcode constants (LOAD 0000011, OP_IMM 0010011, STORE 0100011);
  - Imm_Sel encodings, IMM_MIN = -2048, IMM_MAX = 2047, INSTR_WIDTH = 32.
REQ-030 The combinational field packing plus range check is one natural sub-module, imm_packer; the handshake, address and counters stay in instruction_encoder.

Verification
REQ-031 Reset, then I-type request: Opcode 0010011, Funct3 0, Rd 5, Rs1 6, Imm -5, Out_Ready 1.
  - Required: next cycle Instruction_Code = 0xFFB30293, Instr_Addr = 0.
REQ-032 S-type request: Opcode 0100011, Funct3 010, Rs1 2, Rs2 7, Imm 8.
  - Required: Instruction_Code = 0x00712423, and bits[31:25]/[11:7] sign-extend back to 8.
REQ-033 Boundary immediates: Imm 2047 and -2048 are emitted.
  - Imm 2048 is consumed with no output, and Range_Error = 1, Drop_Count = 1.
REQ-034 Backpressure: Out_Ready held 0 for 3 cycles with In_Valid high.
  - Required: word stable and In_Ready = 0.
  - On release: back-to-back words at consecutive addresses 0, 4, 8.
REQ-035 Load_Base 0xFFFFFFF9 with a simultaneous legal request.
  - Required: word at 0xFFFFFFF8; next word at 0xFFFFFFFC; following word at 0x00000000.
REQ-036 Reset asserted while Out_Valid = 1 and Out_Ready = 0.
  - Required: next cycle Out_Valid = 0, all outputs 0, and the pending word is never transferred.
